// File: rtl/serial_transmitter.sv
// serial_transmitter: FIFO-buffered 7-bit word serialiser, one bit per clock
// Frame: start(0), 7 data bits LSB first, parity, STOP_BITS stop bits(1); line idles high.
module serial_transmitter #(
   parameter int DEPTH      = 4,
   parameter int STOP_BITS  = 1,
   parameter bit PARITY_ODD = 1'b1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [6:0]             data_in,
   input  logic                   data_valid,
   output logic                   data_ready,
   output logic                   serial_out,
   output logic                   busy,
   output logic                   tx_done,
   output logic [$clog2(DEPTH):0] fifo_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(STOP_BITS) + 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        r_state, w_state_nxt;
   logic [6:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [AW:0]   r_level;
   logic [6:0]    r_shift;
   logic          r_par, r_serial;
   logic [2:0]    r_bit_cnt;
   logic [SW-1:0] r_stop_cnt;
   logic [6:0]    w_head;
   logic          w_push, w_pop, w_empty, w_last_stop, w_serial_nxt;

   // Ready comes only from the registered count, so a same-cycle pop never frees a full FIFO
   assign data_ready  = r_level != (AW+1)'(DEPTH);
   assign w_empty     = r_level == '0;
   assign w_push      = data_valid && data_ready;
   assign w_last_stop = r_state == STOP && r_stop_cnt == SW'(STOP_BITS - 1);
   assign w_pop       = !w_empty && (r_state == IDLE || w_last_stop);
   assign w_head      = r_mem[r_rptr];
   assign fifo_level  = r_level;
   assign serial_out  = r_serial;

   always_ff @(posedge clk)
      if (w_push) r_mem[r_wptr] <= data_in;

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) r_state <= IDLE;
      else r_state <= w_state_nxt;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = w_empty ? IDLE : START;
         START:   w_state_nxt = DATA;
         DATA:    w_state_nxt = r_bit_cnt == 3'd6 ? PARITY : DATA;
         PARITY:  w_state_nxt = STOP;
         STOP:    w_state_nxt = !w_last_stop ? STOP : w_empty ? IDLE : START;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Line value for the coming cycle, chosen by the state being entered
   always_comb begin
      w_serial_nxt = 1'b1;
      case (w_state_nxt)
         START:   w_serial_nxt = 1'b0;
         DATA:    w_serial_nxt = r_shift[0];
         PARITY:  w_serial_nxt = r_par;
         default: w_serial_nxt = 1'b1;
      endcase
      busy    = r_state != IDLE || !w_empty;
      tx_done = w_last_stop;
   end

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         r_serial   <= 1'b1;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= '0;
      end else begin
         r_serial <= w_serial_nxt;
         if (w_pop) begin
            r_shift <= w_head;
            r_par   <= PARITY_ODD ? ~^w_head : ^w_head;
         end else if (w_state_nxt == DATA) begin
            r_shift <= r_shift >> 1;
         end
         r_bit_cnt  <= r_state == DATA ? r_bit_cnt + 3'd1 : '0;
         r_stop_cnt <= r_state == STOP ? r_stop_cnt + SW'(1) : '0;
      end
endmodule

// File: tb/tb_serial_transmitter.sv
// tb_serial_transmitter: scoreboard bench; dut 0 is the link default, dut 1 uses two stop bits and even parity.
module tb_serial_transmitter;
   logic            clk, rstn;
   logic [6:0]      data_in;
   logic [1:0]      vld, rdy, ser, busy, done;
   logic [1:0][2:0] lvl;
   logic [7:0]      exp_q [2][$];
   int              st_q [2][$];
   int              checks = 0, errors = 0;

   always #5 clk = ~clk;

   task automatic check(string nm, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int SB = g + 1;
      int         ph = 0;
      int         cyc = 0;
      logic [7:0] got;
      serial_transmitter #(.DEPTH(4), .STOP_BITS(g + 1), .PARITY_ODD(g == 0)) dut (
         .clk(clk), .rstn(rstn), .data_in(data_in), .data_valid(vld[g]),
         .data_ready(rdy[g]), .serial_out(ser[g]), .busy(busy[g]),
         .tx_done(done[g]), .fifo_level(lvl[g]));
      // Frame decoder acting as the receiver; compares each decoded frame with the queue head
      always @(negedge clk) begin
         cyc++;
         if (!rstn) ph = 0;
         else if (ph == 0) begin
            check($sformatf("done_idle%0d", g), done[g], 0);
            if (ser[g] == 1'b0) begin
               ph = 1;
               st_q[g].push_back(cyc);
            end
         end else if (ph <= 8) begin
            got[ph-1] = ser[g];
            check($sformatf("done_early%0d", g), done[g], 0);
            ph++;
         end else begin
            check($sformatf("stop_bit%0d", g), ser[g], 1);
            check($sformatf("tx_done%0d", g), done[g], int'(ph == 8 + SB));
            if (ph == 8 + SB) begin
               if (exp_q[g].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame%0d got %0h expected none", g, got);
               end else check($sformatf("frame%0d", g), got, exp_q[g].pop_front());
               ph = 0;
            end else ph++;
         end
      end
   end

   task automatic push(int g, logic [6:0] w, logic [7:0] e, bit acc);
      data_in = w;
      vld[g] = 1'b1;
      if (acc) exp_q[g].push_back(e);
      @(negedge clk);
      vld[g] = 1'b0;
   endtask

   task automatic wait_idle(int g);
      int n = 0;
      while (busy[g] && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (busy[g]) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout%0d busy=%0b expected 0", g, busy[g]);
      end
      repeat (3) @(negedge clk);
      check($sformatf("drain%0d", g), exp_q[g].size(), 0);
   endtask

   task automatic check_gap(int g, int n, int gap);
      check($sformatf("frames%0d", g), st_q[g].size(), n);
      for (int i = 1; i < st_q[g].size(); i++)
         check($sformatf("gap%0d", g), st_q[g][i] - st_q[g][i-1], gap);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [6:0] w4 [6] = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h7E, 7'h0F};
      logic [7:0] e4 [6] = '{8'h91, 8'hA2, 8'hB3, 8'hC4, 8'h00, 8'h00};
      logic [6:0] w;
      int n, bad;
      clk = 0;
      rstn = 1;
      data_in = '0;
      vld = '0;
      #1 rstn = 0;
      repeat (3) @(negedge clk);
      check("rst_ser", ser[0], 1);
      check("rst_rdy", rdy[0], 1);
      check("rst_busy", busy[0], 0);
      check("rst_done", done[0], 0);
      check("rst_lvl", lvl[0], 0);
      rstn = 1;
      repeat (2) @(negedge clk);
      // single frame, latency and busy fall
      push(0, 7'h55, 8'hD5, 1);
      check("lat_lvl", lvl[0], 1);
      check("lat_idle", ser[0], 1);
      @(negedge clk);
      check("lat_start", ser[0], 0);
      check("lat_lvl0", lvl[0], 0);
      check("lat_busy", busy[0], 1);
      n = 0;
      while (!done[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", done[0], 1);
      @(negedge clk);
      check("busy_fall", busy[0], 0);
      wait_idle(0);
      push(0, 7'h7F, 8'h7F, 1);
      wait_idle(0);
      push(0, 7'h00, 8'h80, 1);
      wait_idle(0);
      // back-to-back frames
      st_q[0].delete();
      check("rdy_b2b", rdy[0], 1);
      push(0, 7'h01, 8'h01, 1);
      check("rdy_b2b", rdy[0], 1);
      push(0, 7'h02, 8'h02, 1);
      check("rdy_b2b", rdy[0], 1);
      push(0, 7'h03, 8'h83, 1);
      wait_idle(0);
      check_gap(0, 3, 10);
      // overflow during a frame: the last two words are dropped
      push(0, 7'h2A, 8'h2A, 1);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         push(0, w4[i], e4[i], i < 4);
         check("full_lvl", lvl[0], i < 3 ? i + 1 : 4);
         check("full_rdy", rdy[0], int'(i < 3));
      end
      n = 0;
      while (!rdy[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rdy_back", rdy[0], 1);
      check("lvl_pop", lvl[0], 3);
      check("start_at_pop", ser[0], 0);
      wait_idle(0);
      // reset in the middle of data bit 3
      push(0, 7'h55, 8'hD5, 1);
      push(0, 7'h2A, 8'h2A, 1);
      repeat (4) @(negedge clk);
      check("bit3", ser[0], 0);
      check("bit3_lvl", lvl[0], 1);
      #2 rstn = 0;
      #1;
      check("abort_ser", ser[0], 1);
      check("abort_lvl", lvl[0], 0);
      check("abort_busy", busy[0], 0);
      check("abort_rdy", rdy[0], 1);
      exp_q[0].delete();
      @(negedge clk);
      #2 rstn = 1;
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (ser[0] !== 1'b1 || busy[0]) bad++;
      end
      check("quiet_after_rst", bad, 0);
      // random words through both configurations
      for (int g = 0; g < 2; g++)
         for (int r = 0; r < 3; r++) begin
            st_q[g].delete();
            for (int i = 0; i < 3; i++) begin
               w = 7'($urandom);
               push(g, w, {g == 0 ? ~^w : ^w, w}, 1);
            end
            wait_idle(g);
            check_gap(g, 3, 10 + g);
         end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_transmitter.md
Name: serial_transmitter

Overview:
- Transmit side of the team's single-wire serial link. It is the counterpart of the existing serial receiver.
- Accepts 7-bit words over a valid/ready handshake and buffers them in a small FIFO. It serialises each word as a frame at one bit per clock.
- Frame format, in order: start bit (0), 7 data bits LSB first, odd parity bit, STOP_BITS stop bits (1).
- Line idles high. Sits between the core logic and the serial pin, sharing the receiver's clock.

Parameters:
- DEPTH, 4, FIFO depth in words. Power of two, ≥2.
- STOP_BITS, 1, stop-bit cycles per frame, ≥1.
- PARITY_ODD, 1, 1 = odd parity (link default); 0 = even parity, for negative testing only.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rstn  input  1  asynchronous, active-low reset
- data_in  input  7  word to transmit
- data_valid  input  1  data_in is valid this cycle
- data_ready  output  1  FIFO can accept a word (= not full)
- serial_out  output  1  serial line, registered
- busy  output  1  frame in progress or FIFO non-empty
- tx_done  output  1  one-cycle pulse, high during the final stop-bit cycle of each frame
- fifo_level  output  clog2(DEPTH)+1  words currently buffered

Behaviour:
- Reset (async, rstn=0): serial_out=1, data_ready=1, busy=0, tx_done=0, fifo_level=0. FIFO flushed, FSM to IDLE, counters cleared.
  - Reset mid-frame aborts the frame and drives the line high immediately.
- Push: occurs on an edge where data_valid && data_ready.
  - data_ready = (fifo_level != DEPTH), purely from registered count.
  - A pop in the same cycle does not make a full FIFO ready.
  - data_valid with data_ready=0 is ignored; the word is dropped and nothing changes.
- Pop: occurs on the edge where FSM leaves IDLE or STOP to START.
  - Push and pop on the same edge: both take effect, fifo_level unchanged.
  - Read/write pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP. serial_out is registered from next-state/shift logic.
  - IDLE: serial_out=1. If FIFO non-empty, pop the head into shift register, latch parity, go to START.
  - START: serial_out=0 for 1 cycle, then go to DATA with bit_cnt=0.
  - DATA: serial_out=shift[0], shift right each cycle. After 7 cycles (bit_cnt==6) go to PARITY.
  - PARITY: serial_out = PARITY_ODD ? ~^word : ^word for 1 cycle, then go to STOP.
  - STOP: serial_out=1 for STOP_BITS cycles.
    - On the last stop cycle tx_done=1.
    - If the FIFO is non-empty at that edge, pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- Latency: a word pushed at edge E into an empty FIFO with FSM idle appears as start bit in the cycle after edge E+1.
- Frame length: 9+STOP_BITS cycles. Back-to-back frames have start bits every 9+STOP_BITS cycles.
  - The receiver needs a high→low edge to detect start; the stop bit guarantees one.
- busy = (state != IDLE) || (fifo_level != 0).
- Words are transmitted in push order. data_in changes after acceptance do not affect buffered words.

Test Plan:
1. Reset, push 7'h55 once → after start, serial_out sequence 0,1,0,1,0,1,0,1,1(parity),1(stop). tx_done high on stop cycle. busy falls the next cycle.
2. Push 7'h7F → data bits all 1, parity bit 0. Push 7'h00 → data bits all 0, parity bit 1.
3. Push 7'h01, 7'h02, 7'h03 on consecutive cycles → three frames with no idle cycles; start bits at offsets 0, 10, 20. Pushes accepted in order; data_ready stays 1.
4. DEPTH=4: push 6 words on consecutive cycles during a frame.
   - data_ready=0 once fifo_level==4.
   - Pushes while full are dropped; exactly the accepted words are transmitted in order.
   - data_ready returns to 1 at the next pop.
5. Assert rstn=0 during the DATA bit 3 cycle → serial_out=1 immediately and fifo_level=0. After release, no frame is sent until the next push.
6. Loopback into the serial receiver with random words, STOP_BITS=1 and 2 → every word is received with ready pulse, matching data_out and parity_ok_n=0. With PARITY_ODD=0 → parity_ok_n=1 on every frame.
